// File: rtl/inference_scheduler_pkg.sv
// Shared definitions for the inference scheduler.
//   - Default sizing constants for the scheduler and its tag FIFO.
//   - Derived index / counter widths.
//   - Issue FSM state encoding.
package inference_scheduler_pkg;

    localparam int NUM_REQ      = 2;
    localparam int FEAT_WIDTH   = 300 * 8;
    localparam int CLASS_WIDTH  = 2;
    localparam int MAX_INFLIGHT = 4;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/inference_scheduler_tag_fifo.sv
// In-order FIFO of requester indices for frames that are inside the pipeline.
// Ports:
//   clk, rst      clock and synchronous active-high reset (empties the FIFO)
//   push, din     enqueue one tag (ignored when full and not popping)
//   pop           dequeue the head tag (ignored when empty)
//   dout          head tag, valid whenever empty is low
//   empty, full   occupancy flags
// Push and pop in the same cycle are both honoured.
module inference_scheduler_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    import inference_scheduler_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    // Head is read combinationally so a returning result is routed without delay.
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inference_scheduler.sv
// Shares one INT8 MLP inference pipeline between NUM_REQ feature sources.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cfg_enable                       gates new grants (an issue in progress completes)
//   req_valid/req_ready/req_features per-requester frame handshake, packed features
//   rsp_valid/rsp_ready/rsp_class    per-requester result handshake, class replicated
//   p_i_valid/p_i_ready/p_i_features pipeline input handshake
//   p_o_valid/p_o_ready/p_o_class    pipeline result handshake
//   inflight                         frames issued but not yet returned
//   err_orphan                       sticky: a result arrived with no tag outstanding
// Requesters are granted round-robin; every issued index is queued in a tag
// FIFO so in-order pipeline results are routed back to their originator.
module inference_scheduler #(
    parameter int NUM_REQ      = inference_scheduler_pkg::NUM_REQ,
    parameter int FEAT_WIDTH   = inference_scheduler_pkg::FEAT_WIDTH,
    parameter int CLASS_WIDTH  = inference_scheduler_pkg::CLASS_WIDTH,
    parameter int MAX_INFLIGHT = inference_scheduler_pkg::MAX_INFLIGHT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_enable,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*FEAT_WIDTH-1:0]   req_features,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [NUM_REQ*CLASS_WIDTH-1:0]  rsp_class,
    output logic                            p_i_valid,
    input  logic                            p_i_ready,
    output logic [FEAT_WIDTH-1:0]           p_i_features,
    input  logic                            p_o_valid,
    output logic                            p_o_ready,
    input  logic [CLASS_WIDTH-1:0]          p_o_class,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                            err_orphan
);
    import inference_scheduler_pkg::*;

    localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    state_e             state_q, state_d;
    logic [GNT_W-1:0]   gnt_q, gnt_d;
    logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic               err_orphan_q, err_orphan_d;

    logic [GNT_W-1:0]   rr_pick;
    logic               rr_found;
    logic [GNT_W-1:0]   head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               issue_hs;
    logic               pop;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx      = 0;
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = GNT_W'(idx);
            end
        end
    end

    assign issue_hs = (state_q == ST_ISSUE) && p_i_ready;
    assign pop      = p_o_valid && !fifo_empty && rsp_ready[head];

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable && (inflight_q < INF_W'(MAX_INFLIGHT)) && rr_found) begin
                    gnt_d   = rr_pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (p_i_ready) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (gnt_q == GNT_W'(NUM_REQ - 1)) ? '0 : gnt_q + GNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d   = inflight_q + INF_W'(issue_hs) - INF_W'(pop);
        err_orphan_d = err_orphan_q | (p_o_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            rr_ptr_q     <= '0;
            inflight_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_ptr_q     <= rr_ptr_d;
            inflight_q   <= inflight_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    inference_scheduler_tag_fifo #(
        .WIDTH (GNT_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_hs),
        .din   (gnt_q),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign p_i_valid    = (state_q == ST_ISSUE);
    // Features are forced to zero outside ISSUE so the bus is quiet when idle.
    assign p_i_features = p_i_valid ? req_features[int'(gnt_q)*FEAT_WIDTH +: FEAT_WIDTH] : '0;

    always_comb begin
        req_ready = '0;
        if (p_i_valid) begin
            req_ready[gnt_q] = p_i_ready;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (p_o_valid && !fifo_empty) begin
            rsp_valid[head] = 1'b1;
        end
    end

    // With no tag outstanding the result is an orphan: accept it to drain it.
    assign p_o_ready = fifo_empty ? p_o_valid : rsp_ready[head];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_class
        assign rsp_class[gi*CLASS_WIDTH +: CLASS_WIDTH] = p_o_class;
    end

    assign inflight   = inflight_q;
    assign err_orphan = err_orphan_q;

    // A granted requester must hold its frame until accepted.
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_ISSUE) |-> req_valid[gnt_q]);

    // Grant gating by inflight keeps the tag FIFO from overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        issue_hs |-> (!fifo_full || pop));

endmodule

// File: tb/tb_inference_scheduler.sv
module tb_inference_scheduler;
    import inference_scheduler_pkg::*;

    localparam int NR  = NUM_REQ;
    localparam int FW  = FEAT_WIDTH;
    localparam int CW  = CLASS_WIDTH;
    localparam int MI  = MAX_INFLIGHT;
    localparam int CNW = CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_enable;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*FW-1:0]  req_features;
    logic [NR*CW-1:0]  rsp_class;
    logic              p_i_valid, p_i_ready;
    logic [FW-1:0]     p_i_features;
    logic              p_o_valid, p_o_ready;
    logic [CW-1:0]     p_o_class;
    logic [CNW-1:0]    inflight;
    logic              err_orphan;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inference_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_enable   (cfg_enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_features (req_features),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_class    (rsp_class),
        .p_i_valid    (p_i_valid),
        .p_i_ready    (p_i_ready),
        .p_i_features (p_i_features),
        .p_o_valid    (p_o_valid),
        .p_o_ready    (p_o_ready),
        .p_o_class    (p_o_class),
        .inflight     (inflight),
        .err_orphan   (err_orphan)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid    = '0;
        req_features = '0;
        rsp_ready    = '0;
        p_i_ready    = 1'b0;
        p_o_valid    = 1'b0;
        p_o_class    = '0;
        cfg_enable   = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [FW-1:0] fill_bytes(input logic [7:0] b);
        return {300{b}};
    endfunction

    function automatic logic [FW-1:0] rand_feat();
        logic [FW-1:0] f;
        for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom();
        return f;
    endfunction

    // Runs cycles with p_i_ready=1 until n issues seen; returns the lanes issued.
    task automatic collect_issues(input int n, input int budget, output int got, output int lanes[8]);
        got = 0;
        for (int i = 0; i < 8; i++) lanes[i] = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (p_i_valid && p_i_ready) begin
                lanes[got] = (req_ready == 2'b01) ? 0 : ((req_ready == 2'b10) ? 1 : -1);
                got++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        req_valid = 2'b11;
        req_features = {fill_bytes(8'h77), fill_bytes(8'h66)};
        tick();
        tick();
        checks++; if (p_i_valid !== 1'b0) begin errors++; $display("FAIL reset_p_i_valid: got %0b want 0", p_i_valid); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (p_o_ready !== 1'b0) begin errors++; $display("FAIL reset_p_o_ready: got %0b want 0", p_o_ready); end
        checks++; if (inflight !== '0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %0b want 0", err_orphan); end
        checks++; if (p_i_features !== '0) begin errors++; $display("FAIL reset_p_i_features: nonzero while in reset"); end
        checks++; if (rsp_class !== '0) begin errors++; $display("FAIL reset_rsp_class: got %h want 0", rsp_class); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 2'b01;
        req_features[0 +: FW] = fill_bytes(8'h05);
        p_i_ready = 1'b1;
        rsp_ready = 2'b11;
        checks++; if (p_i_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %0b want 0", p_i_valid); end
        tick();
        checks++; if (p_i_valid !== 1'b1) begin errors++; $display("FAIL single_p_i_valid: got %0b want 1", p_i_valid); end
        checks++; if (p_i_features !== fill_bytes(8'h05)) begin errors++; $display("FAIL single_features: not all 0x05"); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (inflight !== CNW'(1)) begin errors++; $display("FAIL single_inflight1: got %0d want 1", inflight); end
        p_o_valid = 1'b1;
        p_o_class = 2'd2;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
        checks++; if (rsp_class[0 +: CW] !== 2'd2) begin errors++; $display("FAIL single_rsp_class: got %0d want 2", rsp_class[0 +: CW]); end
        checks++; if (p_o_ready !== 1'b1) begin errors++; $display("FAIL single_p_o_ready: got %0b want 1", p_o_ready); end
        tick();
        p_o_valid = 1'b0;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL single_inflight0: got %0d want 0", inflight); end
    endtask

    task automatic test_contention();
        int exp_lane[4] = '{0, 1, 0, 1};
        logic [CW-1:0] cls[4] = '{2'd0, 2'd1, 2'd2, 2'd1};
        int got;
        int lanes[8];
        do_reset();
        req_valid = 2'b11;
        req_features = {fill_bytes(8'hB1), fill_bytes(8'hA0)};
        p_i_ready = 1'b1;
        collect_issues(4, 40, got, lanes);
        req_valid = '0;
        checks++; if (got !== 4) begin errors++; $display("FAIL contention_issue_count: got %0d want 4 (timeout)", got); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (lanes[k] !== exp_lane[k]) begin errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", k, lanes[k], exp_lane[k]); end
        end
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            p_o_valid = 1'b1;
            p_o_class = cls[k];
            #1;
            checks++; if (rsp_valid !== (NR'(1) << exp_lane[k])) begin errors++; $display("FAIL contention_rsp_valid[%0d]: got %b want lane %0d", k, rsp_valid, exp_lane[k]); end
            checks++; if (rsp_class[exp_lane[k]*CW +: CW] !== cls[k]) begin errors++; $display("FAIL contention_rsp_class[%0d]: got %0d want %0d", k, rsp_class[exp_lane[k]*CW +: CW], cls[k]); end
            tick();
        end
        p_o_valid = 1'b0;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL contention_inflight: got %0d want 0", inflight); end
    endtask

    task automatic test_inflight_limit();
        int got;
        int lanes[8];
        bit seen;
        do_reset();
        req_valid = 2'b10;
        req_features[FW +: FW] = fill_bytes(8'h42);
        p_i_ready = 1'b1;
        collect_issues(8, 30, got, lanes);
        checks++; if (got !== MI) begin errors++; $display("FAIL limit_issue_count: got %0d want %0d", got, MI); end
        checks++; if (inflight !== CNW'(MI)) begin errors++; $display("FAIL limit_inflight: got %0d want %0d", inflight, MI); end
        checks++; if (p_i_valid !== 1'b0) begin errors++; $display("FAIL limit_p_i_valid: got %0b want 0", p_i_valid); end
        p_o_valid = 1'b1;
        p_o_class = 2'd3;
        rsp_ready = 2'b11;
        #1;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL limit_rsp_valid: got %b want 10", rsp_valid); end
        tick();
        p_o_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c <= 2 && !seen; c++) begin
            if (p_i_valid) seen = 1'b1;
            else tick();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL limit_reissue: no issue within 2 cycles of release"); end
    endtask

    task automatic test_backpressure();
        int got;
        int lanes[8];
        do_reset();
        req_valid = 2'b10;
        req_features[FW +: FW] = fill_bytes(8'h11);
        p_i_ready = 1'b1;
        collect_issues(1, 10, got, lanes);
        req_valid = '0;
        p_i_ready = 1'b0;
        checks++; if (got !== 1) begin errors++; $display("FAIL bp_issue: got %0d issues want 1", got); end
        p_o_valid = 1'b1;
        p_o_class = 2'd1;
        rsp_ready = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (p_o_ready !== 1'b0) begin errors++; $display("FAIL bp_p_o_ready[%0d]: got %0b want 0", c, p_o_ready); end
            checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b want 10", c, rsp_valid); end
            checks++; if (rsp_class[CW +: CW] !== 2'd1) begin errors++; $display("FAIL bp_rsp_class[%0d]: got %0d want 1", c, rsp_class[CW +: CW]); end
            tick();
        end
        checks++; if (inflight !== CNW'(1)) begin errors++; $display("FAIL bp_inflight_held: got %0d want 1", inflight); end
        rsp_ready = 2'b10;
        #1;
        checks++; if (p_o_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b want 1", p_o_ready); end
        tick();
        p_o_valid = 1'b0;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL bp_pop: inflight %0d want 0", inflight); end
    endtask

    task automatic test_cfg_disable();
        do_reset();
        req_valid = 2'b01;
        req_features[0 +: FW] = fill_bytes(8'h3C);
        p_i_ready = 1'b0;
        tick();
        cfg_enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (p_i_valid !== 1'b1) begin errors++; $display("FAIL cfg_hold_valid[%0d]: got %0b want 1", c, p_i_valid); end
            tick();
        end
        checks++; if (p_i_features !== fill_bytes(8'h3C)) begin errors++; $display("FAIL cfg_features: not all 0x3C"); end
        p_i_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cfg_req_ready: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            checks++; if (p_i_valid !== 1'b0) begin errors++; $display("FAIL cfg_no_grant[%0d]: got %0b want 0", c, p_i_valid); end
            tick();
        end
        checks++; if (inflight !== CNW'(1)) begin errors++; $display("FAIL cfg_inflight: got %0d want 1", inflight); end
        p_o_valid = 1'b1;
        p_o_class = 2'd2;
        rsp_ready = 2'b11;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL cfg_rsp_valid: got %b want 01", rsp_valid); end
        tick();
        p_o_valid = 1'b0;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL cfg_drain: inflight %0d want 0", inflight); end
        do_reset();
    endtask

    task automatic test_reset_orphan();
        int got;
        int lanes[8];
        do_reset();
        req_valid = 2'b11;
        p_i_ready = 1'b1;
        collect_issues(3, 30, got, lanes);
        req_valid = '0;
        checks++; if (inflight !== CNW'(3)) begin errors++; $display("FAIL ro_inflight3: got %0d want 3", inflight); end
        rst = 1'b1;
        p_i_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL ro_inflight_reset: got %0d want 0", inflight); end
        checks++; if ({p_i_valid, req_ready, rsp_valid, p_o_ready, err_orphan} !== '0) begin errors++; $display("FAIL ro_outputs_low: got %b", {p_i_valid, req_ready, rsp_valid, p_o_ready, err_orphan}); end
        p_o_valid = 1'b1;
        p_o_class = 2'd3;
        rsp_ready = 2'b11;
        #1;
        checks++; if (p_o_ready !== 1'b1) begin errors++; $display("FAIL ro_drain: p_o_ready %0b want 1", p_o_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL ro_rsp_valid: got %b want 00", rsp_valid); end
        tick();
        p_o_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL ro_sticky[%0d]: err_orphan %0b want 1", c, err_orphan); end
            tick();
        end
        checks++; if (inflight !== '0) begin errors++; $display("FAIL ro_no_pop: inflight %0d want 0", inflight); end
        do_reset();
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL ro_clear: err_orphan %0b want 0", err_orphan); end
    endtask

    // Randomised traffic against a transaction-level model: a round-robin
    // pointer over requesters, a queue of outstanding requester indices and a
    // queue of classes the emulated pipeline will return in order.
    task automatic test_random();
        int rr = 0;
        int gnt = 0;
        bit issuing = 1'b0;
        int tagq[$];
        logic [CW-1:0] pipeq[$];
        logic [FW-1:0] feat[NR];
        logic [NR-1:0] exp_rr, exp_rv;
        logic exp_por;
        bit hs, popped;
        int hs_gnt, head;
        do_reset();
        for (int r = 0; r < NR; r++) feat[r] = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    feat[r] = rand_feat();
                    req_valid[r] = 1'b1;
                end
                req_features[r*FW +: FW] = feat[r];
            end
            cfg_enable = ($urandom_range(0, 7) != 0);
            p_i_ready  = ($urandom_range(0, 2) != 0);
            rsp_ready  = NR'($urandom());
            p_o_valid  = (pipeq.size() > 0) && ($urandom_range(0, 1) == 1);
            p_o_class  = (pipeq.size() > 0) ? pipeq[0] : CW'($urandom());
            #1;
            head   = (tagq.size() > 0) ? tagq[0] : 0;
            exp_rr = issuing ? (NR'(p_i_ready) << gnt) : '0;
            exp_rv = (p_o_valid && tagq.size() > 0) ? (NR'(1) << head) : '0;
            exp_por = (tagq.size() > 0) ? rsp_ready[head] : p_o_valid;
            checks++; if (p_i_valid !== issuing) begin errors++; $display("FAIL rnd_p_i_valid cyc %0d: got %0b want %0b", cyc, p_i_valid, issuing); end
            checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL rnd_req_ready cyc %0d: got %b want %b", cyc, req_ready, exp_rr); end
            if (issuing) begin
                checks++; if (p_i_features !== feat[gnt]) begin errors++; $display("FAIL rnd_features cyc %0d: not requester %0d frame", cyc, gnt); end
            end
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid cyc %0d: got %b want %b", cyc, rsp_valid, exp_rv); end
            if (exp_rv != '0) begin
                checks++; if (rsp_class[head*CW +: CW] !== pipeq[0]) begin errors++; $display("FAIL rnd_rsp_class cyc %0d: got %0d want %0d", cyc, rsp_class[head*CW +: CW], pipeq[0]); end
            end
            checks++; if (p_o_ready !== exp_por) begin errors++; $display("FAIL rnd_p_o_ready cyc %0d: got %0b want %0b", cyc, p_o_ready, exp_por); end
            checks++; if (inflight !== CNW'(tagq.size())) begin errors++; $display("FAIL rnd_inflight cyc %0d: got %0d want %0d", cyc, inflight, tagq.size()); end
            checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rnd_err_orphan cyc %0d: got %0b want 0", cyc, err_orphan); end
            hs     = issuing && p_i_ready;
            hs_gnt = gnt;
            popped = p_o_valid && (tagq.size() > 0) && rsp_ready[head];
            if (issuing) begin
                if (hs) begin
                    issuing = 1'b0;
                    rr = (gnt + 1) % NR;
                end
            end else if (cfg_enable && tagq.size() < MI && req_valid != '0) begin
                for (int k = 0; k < NR; k++) begin
                    if (req_valid[(rr + k) % NR]) begin
                        gnt = (rr + k) % NR;
                        break;
                    end
                end
                issuing = 1'b1;
            end
            if (popped) begin
                void'(tagq.pop_front());
                void'(pipeq.pop_front());
            end
            if (hs) begin
                tagq.push_back(hs_gnt);
                pipeq.push_back(feat[hs_gnt][CW-1:0]);
            end
            tick();
            if (hs) req_valid[hs_gnt] = 1'b0;
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_contention();
        test_inflight_limit();
        test_backpressure();
        test_cfg_disable();
        test_reset_orphan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inference_scheduler.md
Name: inference_scheduler

Overview:
- Shares one INT8 MLP inference pipeline (dense → dense → output → argmax; 300 INT8 features in, 2-bit class out) between NUM_REQ feature sources.
- Round-robin arbitrates the pipeline input handshake and limits in-flight frames.
- Records each issued requester index in an in-order tag FIFO and routes every returned class to the requester that issued it.
- Sits between the sensor/feature front-ends and the pipeline top.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- FEAT_WIDTH, 2400, packed feature vector width (300 x INT8).
- CLASS_WIDTH, 2, predicted-class width.
- MAX_INFLIGHT, 4, maximum frames issued but not yet returned (power of 2, ≥1); also the tag FIFO depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  when low, no new issues are granted.
- req_valid  in  NUM_REQ  per-requester frame valid.
- req_ready  out  NUM_REQ  per-requester frame accepted.
- req_features  in  NUM_REQ*FEAT_WIDTH  requester r occupies bits [r*FEAT_WIDTH +: FEAT_WIDTH].
- rsp_valid  out  NUM_REQ  per-requester class valid.
- rsp_ready  in  NUM_REQ  per-requester class accept.
- rsp_class  out  NUM_REQ*CLASS_WIDTH  class, replicated to every lane; only meaningful where rsp_valid is high.
- p_i_valid  out  1  pipeline input valid.
- p_i_ready  in  1  pipeline input ready.
- p_i_features  out  FEAT_WIDTH  pipeline features.
- p_o_valid  in  1  pipeline result valid.
- p_o_ready  out  1  pipeline result ready.
- p_o_class  in  CLASS_WIDTH  pipeline result class.
- inflight  out  clog2(MAX_INFLIGHT+1)  current in-flight count.
- err_orphan  out  1  sticky flag: a result arrived with no tag outstanding.

Behaviour:
- Reset (rst high at a clock edge):
  - FSM goes to IDLE; rr_ptr=0; tag FIFO emptied; inflight=0; err_orphan=0; grant index=0.
  - All outputs low.
  - The pipeline is reset with the same signal (top drives the pipeline's rst_n = ~rst). Frames in flight at reset are discarded and no responses are produced for them.
- FSM states: IDLE, ISSUE.
- IDLE:
  - If cfg_enable && inflight<MAX_INFLIGHT && |req_valid, latch gnt = first requester with req_valid set, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. Go to ISSUE next cycle.
  - Otherwise stay in IDLE.
- ISSUE:
  - p_i_valid=1; p_i_features = req_features slice of gnt (combinational mux on the registered gnt).
  - req_ready[gnt] = p_i_ready; all other req_ready bits 0.
  - On p_i_ready: push gnt into the tag FIFO, set rr_ptr = (gnt+1) mod NUM_REQ, return to IDLE.
  - p_i_valid stays high until the handshake completes. cfg_enable falling does not abort an ISSUE in progress.
- Requester rule: a requester holds req_valid and its features stable until req_ready. If it drops req_valid while granted, that is a protocol violation (assertion); behaviour is undefined.
- Issue throughput: at most one frame per 2 cycles. Minimum latency from req_valid to p_i_valid is 1 cycle.
- Response path (combinational, no added latency):
  - head = tag FIFO head.
  - rsp_valid[head] = p_o_valid && !fifo_empty; all other rsp_valid bits 0.
  - p_o_ready = !fifo_empty && rsp_ready[head].
  - On p_o_valid && p_o_ready: pop the FIFO.
- Orphan result: if p_o_valid && fifo_empty, set p_o_ready=1 to drain the result, set err_orphan=1 (sticky until rst), and do not pop.
- inflight counter:
  - +1 on issue handshake; -1 on pop.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_INFLIGHT. The FIFO cannot overflow because the grant is gated by inflight.
- Ordering: the pipeline is strictly in-order, so FIFO order equals result order.

Decomposition:
- Shared package:
  - Constants NUM_REQ, FEAT_WIDTH (300*8), CLASS_WIDTH, MAX_INFLIGHT.
  - Derived widths IDX_W=clog2(NUM_REQ) and CNT_W=clog2(MAX_INFLIGHT+1).
  - FSM state encoding (IDLE=0, ISSUE=1).
- One sub-module: tag_fifo.
  - Synchronous FIFO, width IDX_W, depth MAX_INFLIGHT.
  - Ports: push, pop, dout (head), empty, full.
  - Supports simultaneous push and pop.
  - Synchronous active-high reset.

Test Plan:
- Single frame: req_valid[0]=1, features=all 0x05, p_i_ready=1 → p_i_valid 1 cycle later with features 0x05…; inflight=1. Pipeline returns class 2 → rsp_valid[0]=1, rsp_class=2; inflight=0.
- Contention: req_valid=2'b11 held, results returned in order as classes 0,1,2,1 → issue order 0,1,0,1; rsp_valid lanes 0,1,0,1 carry classes 0,1,2,1.
- In-flight limit: p_o_valid=0, requester 1 always valid → exactly 4 issues, then p_i_valid stays 0 and inflight=4. Release one result → one more issue within 2 cycles.
- Response backpressure: p_o_valid=1 for a lane-1 result, rsp_ready[1]=0 for 5 cycles → p_o_ready=0 and rsp_valid[1] held with stable class. rsp_ready[1]=1 → pop in that cycle.
- cfg_enable=0 mid-ISSUE: p_i_ready delayed 3 cycles → handshake still completes; no further grants while disabled; in-flight results still delivered.
- Reset and orphan: rst during inflight=3 → next cycle inflight=0 and all outputs low. p_o_valid=1 with empty FIFO → p_o_ready=1, err_orphan=1 and sticky, all rsp_valid bits 0.
